cpu_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for the 16-bit CPU datapath: drives PC into imem, latches
//   the instruction, steers regfile read/write addresses and alu ALU_Code, owns the
//   Z/C flags. Replaces delay-based control with a clocked FSM, 4 cycles/instruction.

---
 rtl/cpu_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Four-cycle instruction sequencer for the 16-bit CPU datapath (IDLE/FETCH/DECODE/EXEC/WB/HALT).
// Optional feature: define CPU_BRANCH_EN to decode opcode 7'h41 as BZ (branch if flag_z).
module cpu_seq_ctrl #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter logic [6:0]  HALT_OPCODE = 7'h7F,
  parameter logic [6:0]  NOP_OPCODE  = 7'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [15:0] pc,
  output logic [2:0]  rega,
  output logic [2:0]  regb,
  output logic [2:0]  wreg,
  output logic [2:0]  alu_code,
  output logic        write_en,
  output logic        flag_z,
  output logic        flag_c,
  output logic        busy,
  output logic        halted,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t      state;
  logic [15:0] ir;
  logic [6:0]  opcode;
  logic        is_nop, is_halt, is_alu, is_bz, is_illegal;
  logic [15:0] next_pc;

  assign opcode  = ir[15:9];
  assign is_nop  = (opcode == NOP_OPCODE);
  assign is_halt = (opcode == HALT_OPCODE);
  assign is_alu  = ~ir[15] & ~is_nop & ~is_halt;

  // Register addresses come straight from IR, so they are valid from DECODE until the next fetch.
  assign rega = ir[5:3];
  assign regb = ir[2:0];
  assign wreg = ir[8:6];

`ifdef CPU_BRANCH_EN
  logic take_branch;
  assign is_bz       = (opcode == 7'h41);
  assign take_branch = is_bz & flag_z;
  assign next_pc     = pc + 16'd1 + (take_branch ? {{7{ir[8]}}, ir[8:0]} : 16'd0);
`else
  assign is_bz   = 1'b0;
  assign next_pc = pc + 16'd1;
`endif

  assign is_illegal = ~ir[15] ? 1'b0 : ~(is_nop | is_halt | is_bz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= PC_RESET;
      ir       <= '0;
      alu_code <= '0;
      write_en <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      write_en <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          ir    <= instruction;
          state <= DECODE;
        end
        DECODE: begin
          state    <= EXEC;
          alu_code <= is_alu ? ir[11:9] : 3'd0;
        end
        // Strobes for WB are set here so they appear as registered pulses during WB itself.
        EXEC: begin
          state    <= WB;
          alu_code <= 3'd0;
          retire   <= 1'b1;
          illegal  <= is_illegal;
          if (is_alu) begin
            flag_z   <= alu_zero;
            flag_c   <= alu_carry;
            write_en <= 1'b1;
          end
        end
        WB: begin
          if (is_halt) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            pc <= next_pc;
            if (run) begin
              state <= FETCH;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: hand-computed vector table, corner-case sequences, and random
// instructions checked against an instruction-level model. Honours CPU_BRANCH_EN.
module tb_cpu_seq_ctrl;

  typedef struct {
    logic [15:0] instr;
    logic        az;
    logic        ac;
    logic [2:0]  alu_code;
    logic        we;
    logic        ill;
    logic        halt;
    logic [15:0] pc_after;
    logic        fz;
    logic        fc;
  } vec_t;

`ifdef CPU_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, run, alu_zero, alu_carry;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic [2:0]  rega, regb, wreg, alu_code;
  logic        write_en, flag_z, flag_c, busy, halted, retire, illegal;

  logic        run_w;
  logic [15:0] instr_w, pc_w;
  logic [2:0]  rega_w, regb_w, wreg_w, alu_code_w;
  logic        write_en_w, flag_z_w, flag_c_w, busy_w, halted_w, retire_w, illegal_w;

  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] exp_pc;
  logic        m_fz, m_fc;
  vec_t        tbl [9];

  always #5 clk = ~clk;

  cpu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .pc(pc), .rega(rega), .regb(regb),
    .wreg(wreg), .alu_code(alu_code), .write_en(write_en), .flag_z(flag_z),
    .flag_c(flag_c), .busy(busy), .halted(halted), .retire(retire), .illegal(illegal)
  );

  cpu_seq_ctrl #(.PC_RESET(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run_w), .instruction(instr_w),
    .alu_zero(1'b0), .alu_carry(1'b0), .pc(pc_w), .rega(rega_w), .regb(regb_w),
    .wreg(wreg_w), .alu_code(alu_code_w), .write_en(write_en_w), .flag_z(flag_z_w),
    .flag_c(flag_c_w), .busy(busy_w), .halted(halted_w), .retire(retire_w), .illegal(illegal_w)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input logic az, input logic ac);
    instruction = instr;
    alu_zero    = az;
    alu_carry   = ac;
  endtask

  // Instruction-level model: one call per instruction, no notion of cycles or states.
  function automatic vec_t predict(input logic [15:0] instr, input logic az, input logic ac,
                                   input logic [15:0] cur_pc, input logic fz, input logic fc);
    vec_t v;
    int   op, off;
    op = int'(instr[15:9]);
    v.instr = instr; v.az = az; v.ac = ac;
    v.alu_code = 3'd0; v.we = 1'b0; v.ill = 1'b0; v.halt = 1'b0;
    v.pc_after = 16'(int'(cur_pc) + 1);
    v.fz = fz; v.fc = fc;
    if (op < 64) begin
      v.alu_code = instr[11:9];
      v.we = 1'b1; v.fz = az; v.fc = ac;
    end else if (op == 127) begin
      v.halt = 1'b1;
      v.pc_after = cur_pc;
    end else if (op == 64) begin
      v.ill = 1'b0;
    end else if (op == 65 && BR) begin
      off = instr[8] ? int'(instr[8:0]) - 512 : int'(instr[8:0]);
      if (fz) v.pc_after = 16'(int'(cur_pc) + 1 + off);
    end else begin
      v.ill = 1'b1;
    end
    return v;
  endfunction

  // Entered at the negedge of a FETCH cycle; leaves at the negedge after WB.
  task automatic runInstr(input vec_t v);
    logic [15:0] pc0;
    pc0 = exp_pc;
    checkOutput("fetch_pc", pc, pc0);
    checkOutput("fetch_busy", 16'(busy), 16'd1);
    applyStimulus(v.instr, v.az, v.ac);
    @(negedge clk);
    checkOutput("dec_rega", 16'(rega), 16'(v.instr[5:3]));
    checkOutput("dec_regb", 16'(regb), 16'(v.instr[2:0]));
    checkOutput("dec_wreg", 16'(wreg), 16'(v.instr[8:6]));
    checkOutput("dec_we", 16'(write_en), 16'd0);
    @(negedge clk);
    checkOutput("exec_alu_code", 16'(alu_code), 16'(v.alu_code));
    checkOutput("exec_we", 16'(write_en), 16'd0);
    checkOutput("exec_retire", 16'(retire), 16'd0);
    @(negedge clk);
    checkOutput("wb_we", 16'(write_en), 16'(v.we));
    checkOutput("wb_retire", 16'(retire), 16'd1);
    checkOutput("wb_illegal", 16'(illegal), 16'(v.ill));
    checkOutput("wb_pc", pc, pc0);
    @(negedge clk);
    checkOutput("next_pc", pc, v.pc_after);
    checkOutput("flag_z", 16'(flag_z), 16'(v.fz));
    checkOutput("flag_c", 16'(flag_c), 16'(v.fc));
    checkOutput("halted", 16'(halted), 16'(v.halt));
    checkOutput("busy", 16'(busy), 16'(!v.halt));
    checkOutput("post_we", 16'(write_en), 16'd0);
    checkOutput("post_retire", 16'(retire), 16'd0);
    exp_pc = v.pc_after;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    logic [15:0] ins;
    tbl[0] = '{16'h0053, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1};
    tbl[1] = '{16'h1A5C, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
    tbl[3] = '{16'hA000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 1'b0};
    tbl[4] = '{16'h7E3F, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 16'd5, 1'b1, 1'b1};
    tbl[5] = '{16'h83FC, 1'b0, 1'b0, 3'd0, 1'b0, !BR, 1'b0, BR ? 16'd2 : 16'd6, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, BR ? 16'd3 : 16'd7, 1'b0, 1'b0};
    tbl[7] = '{16'h83FC, 1'b1, 1'b1, 3'd0, 1'b0, !BR, 1'b0, BR ? 16'd4 : 16'd8, 1'b0, 1'b0};
    tbl[8] = '{16'hFE00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, BR ? 16'd4 : 16'd8, 1'b0, 1'b0};

    rst_n = 1'b0; run = 1'b0; run_w = 1'b0; instr_w = 16'h0000;
    applyStimulus(16'h0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", pc, 16'h0000);
    checkOutput("rst_we", 16'(write_en), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_halted", 16'(halted), 16'd0);
    checkOutput("rst_retire", 16'(retire), 16'd0);
    checkOutput("rst_wreg", 16'(wreg), 16'd0);
    checkOutput("rst_wrap_pc", pc_w, 16'hFFFF);

    rst_n = 1'b1; run = 1'b1; exp_pc = 16'h0000;
    @(negedge clk);
    foreach (tbl[i]) runInstr(tbl[i]);
    repeat (4) begin
      @(negedge clk);
      checkOutput("halt_we", 16'(write_en), 16'd0);
      checkOutput("halt_retire", 16'(retire), 16'd0);
      checkOutput("halt_pc", pc, exp_pc);
      checkOutput("halt_halted", 16'(halted), 16'd1);
    end

    // Asynchronous reset out of HALT takes effect without a clock edge.
    rst_n = 1'b0; run = 1'b0;
    #1;
    checkOutput("arst_pc", pc, 16'h0000);
    checkOutput("arst_halted", 16'(halted), 16'd0);
    checkOutput("arst_busy", 16'(busy), 16'd0);
    checkOutput("arst_we", 16'(write_en), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 16'(busy), 16'd0);

    // run dropped during EXEC: instruction still completes, then back to IDLE.
    run = 1'b1;
    @(negedge clk);
    checkOutput("drop_fetch_pc", pc, 16'h0000);
    applyStimulus(16'h0053, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checkOutput("drop_wb_we", 16'(write_en), 16'd1);
    checkOutput("drop_wb_retire", 16'(retire), 16'd1);
    @(negedge clk);
    checkOutput("drop_pc", pc, 16'h0001);
    checkOutput("drop_flag_z", 16'(flag_z), 16'd1);
    repeat (3) begin
      checkOutput("drop_busy", 16'(busy), 16'd0);
      checkOutput("drop_we", 16'(write_en), 16'd0);
      @(negedge clk);
    end
    checkOutput("drop_pc_hold", pc, 16'h0001);

    // Reset pulsed during EXEC aborts the instruction before any write strobe.
    run = 1'b1;
    @(negedge clk);
    checkOutput("abort_fetch_pc", pc, 16'h0001);
    applyStimulus(16'h0053, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we", 16'(write_en), 16'd0);
    checkOutput("abort_pc", pc, 16'h0000);
    checkOutput("abort_busy", 16'(busy), 16'd0);
    @(negedge clk);
    checkOutput("abort_we2", 16'(write_en), 16'd0);
    checkOutput("abort_retire", 16'(retire), 16'd0);
    checkOutput("abort_flag_c", 16'(flag_c), 16'd0);
    run = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle", 16'(busy), 16'd0);

    // PC wrap on the instance reset to 16'hFFFF.
    run_w = 1'b1; instr_w = 16'h8000;
    @(negedge clk);
    checkOutput("wrap_fetch_pc", pc_w, 16'hFFFF);
    checkOutput("wrap_busy", 16'(busy_w), 16'd1);
    @(negedge clk);
    @(negedge clk);
    run_w = 1'b0;
    @(negedge clk);
    checkOutput("wrap_retire", 16'(retire_w), 16'd1);
    checkOutput("wrap_we", 16'(write_en_w), 16'd0);
    checkOutput("wrap_illegal", 16'(illegal_w), 16'd0);
    @(negedge clk);
    checkOutput("wrap_pc", pc_w, 16'h0000);
    checkOutput("wrap_idle", 16'(busy_w), 16'd0);

    // Random instruction stream against the instruction-level model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; exp_pc = 16'h0000; m_fz = 1'b0; m_fc = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        5:       ins = {7'h40, 9'($urandom)};
        6, 7:    ins = {7'h41, 9'($urandom)};
        8:       ins = {7'($urandom_range(66, 126)), 9'($urandom)};
        default: ins = {1'b0, 15'($urandom)};
      endcase
      v = predict(ins, 1'($urandom), 1'($urandom), exp_pc, m_fz, m_fc);
      runInstr(v);
      m_fz = v.fz; m_fc = v.fc;
    end
    v = predict(16'hFE00, 1'b0, 1'b0, exp_pc, m_fz, m_fc);
    runInstr(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
